payload_sym_ctrl: RTL and testbench

Payload symbol sequencer sitting between the payload padding unit and the payload interleaver/mapper chain. It arms on a frame start and accepts the padded coded payload bit stream (encoded payload followed by padding bits). It slices the stream into OFDM symbols of a fixed number of coded bits, tags symbol boundaries and symbol index for downstream, and reports frame completion. It detects length and stall errors so that the TX frame controller can abort cleanly.

---
 rtl/payload_sym_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_payload_sym_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/payload_sym_ctrl.sv
// Payload symbol sequencer: slices the padded coded payload bit stream into OFDM
// symbols, tags symbol boundaries and index, and flags length/stall errors.
// The output bit is named do_bit because "do" is a reserved word.
module payload_sym_ctrl #(
  parameter int unsigned BitsPerSym = 1920,
  parameter int unsigned MaxSym     = 15,
  parameter int unsigned Timeout    = 4096,
  parameter int unsigned GapMax     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       di,
  input  logic       di_vld,
  input  logic [3:0] di_sym_num,
  output logic       do_bit,
  output logic       do_vld,
  output logic       do_sym_start,
  output logic       do_sym_end,
  output logic [3:0] do_sym_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned TmoW = $clog2(Timeout);
  localparam int unsigned GapW = $clog2(GapMax + 1);
  localparam logic [10:0]     LastBit = 11'(BitsPerSym - 1);
  localparam logic [3:0]      MaxSymL = 4'(MaxSym);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(Timeout - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GapMax);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StDone, StErr} state_e;

  state_e          state_q, state_d;
  logic [10:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]      sym_cnt_q, sym_cnt_d;
  logic [3:0]      num_sym_q, num_sym_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]      win_q, win_d;  // post-done overrun watch window
  logic            do_q, do_d, do_vld_q, do_vld_d;
  logic            sym_start_q, sym_start_d, sym_end_q, sym_end_d;
  logic [3:0]      idx_q, idx_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            fwd;
  logic [3:0]      num_eff;

  // Symbol count in effect: the live input on the arming bit, the latched value after.
  assign num_eff = (state_q == StArm) ? di_sym_num : num_sym_q;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    num_sym_d   = num_sym_q;
    gap_cnt_d   = gap_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    win_d       = win_q;
    do_d        = 1'b0;
    do_vld_d    = 1'b0;
    sym_start_d = 1'b0;
    sym_end_d   = 1'b0;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    code_d      = code_q;
    fwd         = 1'b0;

    unique case (state_q)
      StIdle, StErr: begin
        if (win_q != 2'd0) win_d = win_q - 2'd1;
        if (start) begin
          state_d   = StArm;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          code_d    = 2'd0;
          bit_cnt_d = '0;
          sym_cnt_d = '0;
          gap_cnt_d = '0;
          tmo_cnt_d = '0;
          idx_d     = '0;
          win_d     = '0;
        end else if (state_q == StIdle && di_vld && win_q != 2'd0) begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end
      StArm: begin
        if (di_vld) begin
          num_sym_d = di_sym_num;
          if (di_sym_num == 4'd0 || di_sym_num > MaxSymL) begin
            state_d = StErr;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end else begin
            state_d = StRun;
            fwd     = 1'b1;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          state_d = StErr;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (di_vld) begin
          gap_cnt_d = '0;
          fwd       = 1'b1;
        end else if (gap_cnt_q == GapLast) begin
          state_d = StErr;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        win_d   = 2'd2;
        if (di_vld) begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fwd) begin
      do_d        = di;
      do_vld_d    = 1'b1;
      sym_start_d = (bit_cnt_q == 11'd0);
      sym_end_d   = (bit_cnt_q == LastBit);
      idx_d       = sym_cnt_q;
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d = '0;
        sym_cnt_d = sym_cnt_q + 4'd1;
        if (sym_cnt_q == num_eff - 4'd1) state_d = StDone;
      end else begin
        bit_cnt_d = bit_cnt_q + 11'd1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      num_sym_q   <= '0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      win_q       <= '0;
      do_q        <= 1'b0;
      do_vld_q    <= 1'b0;
      sym_start_q <= 1'b0;
      sym_end_q   <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      num_sym_q   <= num_sym_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      win_q       <= win_d;
      do_q        <= do_d;
      do_vld_q    <= do_vld_d;
      sym_start_q <= sym_start_d;
      sym_end_q   <= sym_end_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign do_bit       = do_q;
  assign do_vld       = do_vld_q;
  assign do_sym_start = sym_start_q;
  assign do_sym_end   = sym_end_q;
  assign do_sym_idx   = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;

endmodule

// File: tb/tb_payload_sym_ctrl.sv
// Directed bench for payload_sym_ctrl: framing, gaps, timeout, bad count, overrun, reset.
module tb_payload_sym_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, di, di_vld;
  logic [3:0] di_sym_num;
  logic       do_bit, do_vld, do_sym_start, do_sym_end, busy, done, err;
  logic [3:0] do_sym_idx;
  logic [1:0] err_code;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  payload_sym_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .di           (di),
    .di_vld       (di_vld),
    .di_sym_num   (di_sym_num),
    .do_bit       (do_bit),
    .do_vld       (do_vld),
    .do_sym_start (do_sym_start),
    .do_sym_end   (do_sym_end),
    .do_sym_idx   (do_sym_idx),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code)
  );

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Deterministic payload bit pattern
  function automatic logic pat(input int k);
    int t;
    t = k ^ (k >> 3) ^ (k >> 7);
    return t[0];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
    chk1("err_cleared", err, 1'b0);
    chk4("code_cleared", {2'b00, err_code}, 4'd0);
  endtask

  // Drive nbits valid bits, optional gap before bit gap_at and extra start at bit start_at.
  task automatic drive_frame(input int nbits, input int sn, input int gap_at,
                             input int gap_len, input int start_at);
    for (int k = 0; k < nbits; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          di_vld = 1'b0;
          di     = 1'b0;
          tick();
          chk1("gap_vld", do_vld, 1'b0);
          chk1("gap_busy", busy, 1'b1);
          chk1("gap_err", err, 1'b0);
        end
      end
      di         = pat(k);
      di_vld     = 1'b1;
      di_sym_num = 4'(sn);
      start      = (k == start_at);
      tick();
      start = 1'b0;
      chk1("do_vld", do_vld, 1'b1);
      chk1("do", do_bit, pat(k));
      chk1("sym_start", do_sym_start, (k % 1920) == 0);
      chk1("sym_end", do_sym_end, (k % 1920) == 1919);
      chk4("sym_idx", do_sym_idx, 4'(k / 1920));
      chk1("busy_run", busy, 1'b1);
      chk1("err_run", err, 1'b0);
      chk1("done_run", done, 1'b0);
    end
    di_vld = 1'b0;
  endtask

  task automatic expect_done();
    tick();
    chk1("done_pulse", done, 1'b1);
    chk1("busy_at_done", busy, 1'b0);
    chk1("vld_at_done", do_vld, 1'b0);
    chk1("err_at_done", err, 1'b0);
    tick();
    chk1("done_once", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; di = 1'b0; di_vld = 1'b0; di_sym_num = 4'd5;
    tick();
    tick();
    chk1("rst_do", do_bit, 1'b0);
    chk1("rst_vld", do_vld, 1'b0);
    chk1("rst_ss", do_sym_start, 1'b0);
    chk1("rst_se", do_sym_end, 1'b0);
    chk4("rst_idx", do_sym_idx, 4'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk4("rst_code", {2'b00, err_code}, 4'd0);
    rst = 1'b0;

    // Stray valid in idle, long after any done: ignored
    di_vld = 1'b1;
    tick();
    di_vld = 1'b0;
    tick();
    chk1("stray_err", err, 1'b0);
    chk1("stray_vld", do_vld, 1'b0);

    // Contiguous 5-symbol frame
    pulse_start();
    drive_frame(9600, 5, -1, 0, -1);
    expect_done();

    // 10-cycle gap at bit 8640
    pulse_start();
    drive_frame(9600, 5, 8640, 10, -1);
    expect_done();

    // 64-cycle gap is legal, the 65th gap cycle errors
    pulse_start();
    drive_frame(3000, 5, -1, 0, -1);
    repeat (64) tick();
    chk1("gap64_err", err, 1'b0);
    chk1("gap64_busy", busy, 1'b1);
    tick();
    chk1("gap65_err", err, 1'b1);
    chk4("gap65_code", {2'b00, err_code}, 4'd2);
    chk1("gap65_busy", busy, 1'b0);
    di_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      di = pat(i);
      tick();
      chk1("err_no_fwd", do_vld, 1'b0);
      chk1("err_sticky", err, 1'b1);
    end
    di_vld = 1'b0;

    // Timeout: 4096 armed cycles with no valid
    pulse_start();
    repeat (4095) tick();
    chk1("tmo_early_err", err, 1'b0);
    tick();
    chk1("tmo_err", err, 1'b1);
    chk4("tmo_code", {2'b00, err_code}, 4'd2);
    chk1("tmo_busy", busy, 1'b0);

    // Bad symbol count on the first bit
    pulse_start();
    di_sym_num = 4'd0;
    di_vld     = 1'b1;
    di         = 1'b1;
    tick();
    chk1("sym0_err", err, 1'b1);
    chk4("sym0_code", {2'b00, err_code}, 4'd1);
    chk1("sym0_vld", do_vld, 1'b0);
    chk1("sym0_busy", busy, 1'b0);
    tick();
    chk1("sym0_vld2", do_vld, 1'b0);
    di_vld = 1'b0;

    // Overrun: one extra valid bit right after the last one
    pulse_start();
    drive_frame(9600, 5, -1, 0, -1);
    di_vld = 1'b1;
    di     = 1'b1;
    tick();
    di_vld = 1'b0;
    chk1("ovr_done", done, 1'b1);
    chk1("ovr_vld", do_vld, 1'b0);
    chk1("ovr_err", err, 1'b1);
    chk4("ovr_code", {2'b00, err_code}, 4'd3);
    tick();
    chk1("ovr_done_once", done, 1'b0);
    chk1("ovr_err_sticky", err, 1'b1);

    // Reset mid-frame at bit 5000
    pulse_start();
    drive_frame(5000, 5, -1, 0, -1);
    rst    = 1'b1;
    di_vld = 1'b1;
    tick();
    rst    = 1'b0;
    di_vld = 1'b0;
    chk1("mrst_vld", do_vld, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk4("mrst_idx", do_sym_idx, 4'd0);
    chk1("mrst_err", err, 1'b0);
    chk1("mrst_se", do_sym_end, 1'b0);

    // Clean frame with an ignored second start during RUN
    pulse_start();
    drive_frame(9600, 5, -1, 0, 4000);
    expect_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
